// File: rtl/regfile_debug_arbiter_pkg.sv
// Shared types and constants for the register-file port-A debug arbiter.
package regfile_debug_arbiter_pkg;

   typedef enum logic [2:0] {
      DBG_ST_IDLE,
      DBG_ST_WAIT_SLOT,
      DBG_ST_ACCESS,
      DBG_ST_CAPTURE,
      DBG_ST_DONE
   } dbg_state_t;

   localparam logic DBG_WE_READ  = 1'b0;
   localparam logic DBG_WE_WRITE = 1'b1;

   localparam logic [1:0] REG_BYTE_ENX_BOTH = 2'b11;

   // Reads may only use FETCH (or HALT); writes may also use DECODE.
   function automatic logic dbg_slot(input logic we, input logic fetch,
                                     input logic decode, input logic halt);
      return fetch | halt | ((we == DBG_WE_WRITE) & decode);
   endfunction

endpackage

// File: rtl/regfile_debug_arbiter_if.sv
// Debug requester bus: level request held until a one-cycle ACK pulse.
interface regfile_debug_arbiter_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) ();

   logic              DBG_REQ;
   logic              DBG_WE;
   logic [ADDR_W-1:0] DBG_ADDR;
   logic [DATA_W-1:0] DBG_WDATA;
   logic              DBG_ACK;
   logic              DBG_ERR;
   logic [DATA_W-1:0] DBG_RDATA;

   modport master (
      output DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
      input  DBG_ACK, DBG_ERR, DBG_RDATA
   );

   modport slave (
      input  DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
      output DBG_ACK, DBG_ERR, DBG_RDATA
   );

endinterface

// File: rtl/regfile_debug_arbiter.sv
// Shares register-file port A between the core and a debug requester; the core
// always wins and debug accesses are slotted into idle phases or HALT.
module regfile_debug_arbiter
   import regfile_debug_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FETCH,
   input  logic              DECODE,
   input  logic              HALT,
   input  logic              CORE_REGA_EN,
   input  logic              CORE_REGA_WEN,
   input  logic [1:0]        CORE_BYTE_EN,
   input  logic [ADDR_W-1:0] CORE_ADDRA,
   input  logic [DATA_W-1:0] REGA_DOUT,
   regfile_debug_arbiter_if.slave dbg,
   output logic              REGA_EN,
   output logic              REGA_WEN,
   output logic [1:0]        REGA_BYTE_EN,
   output logic [ADDR_W-1:0] ADDRA,
   output logic              DIN_SEL,
   output logic [DATA_W-1:0] DBG_WDATA_Q
);

   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   dbg_state_t        state;
   dbg_state_t        state_nxt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              go;

   assign go = dbg_slot(we_q, FETCH, DECODE, HALT) & ~CORE_REGA_EN;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= DBG_ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DBG_ST_IDLE:      if (dbg.DBG_REQ) state_nxt = DBG_ST_WAIT_SLOT;
         DBG_ST_WAIT_SLOT: begin
            if (go)                  state_nxt = DBG_ST_ACCESS;
            else if (cnt == MAX_CNT) state_nxt = DBG_ST_DONE;
         end
         DBG_ST_ACCESS:    state_nxt = (we_q == DBG_WE_READ) ? DBG_ST_CAPTURE : DBG_ST_DONE;
         DBG_ST_CAPTURE:   state_nxt = DBG_ST_DONE;
         DBG_ST_DONE:      state_nxt = DBG_ST_IDLE;
         default:          state_nxt = DBG_ST_IDLE;
      endcase
   end

   // Request fields are captured only on accept; the counter stops at MAX_CNT.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         we_q        <= DBG_WE_READ;
         addr_q      <= '0;
         DBG_WDATA_Q <= '0;
         cnt         <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         case (state)
            DBG_ST_IDLE: if (dbg.DBG_REQ) begin
               we_q        <= dbg.DBG_WE;
               addr_q      <= dbg.DBG_ADDR;
               DBG_WDATA_Q <= dbg.DBG_WDATA;
               cnt         <= '0;
               err_q       <= 1'b0;
            end
            DBG_ST_WAIT_SLOT: if (!go) begin
               if (cnt == MAX_CNT) err_q <= 1'b1;
               else                cnt   <= cnt + 1'b1;
            end
            DBG_ST_CAPTURE: rdata_q <= REGA_DOUT;
            default: ;
         endcase
      end
   end

   always_comb begin
      REGA_EN       = CORE_REGA_EN;
      REGA_WEN      = CORE_REGA_WEN;
      REGA_BYTE_EN  = CORE_BYTE_EN;
      ADDRA         = CORE_ADDRA;
      DIN_SEL       = 1'b0;
      dbg.DBG_ACK   = 1'b0;
      dbg.DBG_ERR   = 1'b0;
      dbg.DBG_RDATA = rdata_q;
      case (state)
         DBG_ST_ACCESS: begin
            REGA_EN      = 1'b1;
            REGA_WEN     = (we_q == DBG_WE_WRITE);
            REGA_BYTE_EN = REG_BYTE_ENX_BOTH;
            ADDRA        = addr_q;
            DIN_SEL      = (we_q == DBG_WE_WRITE);
         end
         DBG_ST_DONE: begin
            dbg.DBG_ACK = 1'b1;
            dbg.DBG_ERR = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Scoreboard bench: a 4-phase core model plus directed debug requests; a
// negedge monitor checks port A every cycle and every ACK against queued expectations.
module tb_regfile_debug_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned MW = 15;

   typedef struct {
      int          cyc;
      logic [3:0]  addr;
      bit          we;
      logic [15:0] wd;
   } acc_t;

   typedef struct {
      int          cyc;
      bit          err;
      logic [15:0] rd;
   } ack_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        FETCH, DECODE, HALT;
   logic        CORE_REGA_EN, CORE_REGA_WEN;
   logic [1:0]  CORE_BYTE_EN;
   logic [3:0]  CORE_ADDRA;
   logic [15:0] REGA_DOUT = '0;
   logic        REGA_EN, REGA_WEN, DIN_SEL;
   logic [1:0]  REGA_BYTE_EN;
   logic [3:0]  ADDRA;
   logic [15:0] DBG_WDATA_Q;
   logic [15:0] wd_mux;
   logic [15:0] mem [16];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   ph;
   bit   core_on, core_force, halt_on;
   logic [15:0] last_rd;
   acc_t acc_q[$];
   ack_t ack_q[$];
   acc_t ma;
   ack_t mk;

   regfile_debug_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) dbg ();

   regfile_debug_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .HALT(HALT),
      .CORE_REGA_EN(CORE_REGA_EN), .CORE_REGA_WEN(CORE_REGA_WEN),
      .CORE_BYTE_EN(CORE_BYTE_EN), .CORE_ADDRA(CORE_ADDRA), .REGA_DOUT(REGA_DOUT),
      .dbg(dbg), .REGA_EN(REGA_EN), .REGA_WEN(REGA_WEN), .REGA_BYTE_EN(REGA_BYTE_EN),
      .ADDRA(ADDRA), .DIN_SEL(DIN_SEL), .DBG_WDATA_Q(DBG_WDATA_Q)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Register file with 1-cycle synchronous read; core writes carry a fixed pattern.
   assign wd_mux = DIN_SEL ? DBG_WDATA_Q : 16'h1234;
   always @(posedge CLK) begin
      if (REGA_EN) begin
         if (REGA_WEN && REGA_BYTE_EN[0]) mem[ADDRA][7:0]  <= wd_mux[7:0];
         if (REGA_WEN && REGA_BYTE_EN[1]) mem[ADDRA][15:8] <= wd_mux[15:8];
         REGA_DOUT <= mem[ADDRA];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (!RESET) begin
         if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
            ma = acc_q.pop_front();
            check("access_port", {REGA_EN, REGA_WEN, REGA_BYTE_EN, ADDRA, DIN_SEL},
                  {1'b1, ma.we, 2'b11, ma.addr, ma.we});
            if (ma.we) check("access_wdata", DBG_WDATA_Q, ma.wd);
         end else begin
            if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
               ma = acc_q.pop_front();
               check("access_missing", 32'(cyc), 32'(ma.cyc));
            end
            check("passthrough", {REGA_EN, REGA_WEN, REGA_BYTE_EN, ADDRA, DIN_SEL},
                  {CORE_REGA_EN, CORE_REGA_WEN, CORE_BYTE_EN, CORE_ADDRA, 1'b0});
         end
         if (dbg.DBG_ACK) begin
            if (ack_q.size() == 0) begin
               check("ack_unexpected", 32'(dbg.DBG_ACK), 32'd0);
            end else begin
               mk = ack_q.pop_front();
               check("ack_cycle", 32'(cyc), 32'(mk.cyc));
               check("ack_err", 32'(dbg.DBG_ERR), 32'(mk.err));
               check("ack_rdata", dbg.DBG_RDATA, mk.rd);
            end
         end else begin
            check("err_without_ack", 32'(dbg.DBG_ERR), 32'd0);
            if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
               mk = ack_q.pop_front();
               check("ack_missing", 32'(cyc), 32'(mk.cyc));
            end
         end
      end
   end

   // Phases: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 COMMIT; the core uses port A in 2 and 3.
   task automatic drive_phase();
      FETCH         = !halt_on && ph == 0;
      DECODE        = !halt_on && ph == 1;
      HALT          = halt_on;
      CORE_REGA_EN  = core_force || (!halt_on && core_on && ph >= 2);
      CORE_REGA_WEN = CORE_REGA_EN && ph == 3;
      CORE_BYTE_EN  = 2'b01;
      CORE_ADDRA    = 4'hE;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      ph = (ph + 1) % 4;
      drive_phase();
   endtask

   task automatic goto_phase(input int p);
      for (int i = 0; i < 4 && ph != p; i++) tick();
   endtask

   task automatic issue(input bit we, input logic [3:0] addr, input logic [15:0] wd,
                        input int acc_off);
      acc_t a;
      dbg.DBG_WE    = we;
      dbg.DBG_ADDR  = addr;
      dbg.DBG_WDATA = wd;
      dbg.DBG_REQ   = 1'b1;
      if (acc_off > 0) begin
         a.cyc = cyc + acc_off; a.addr = addr; a.we = we; a.wd = wd;
         acc_q.push_back(a);
      end
   endtask

   task automatic req(input bit we, input logic [3:0] addr, input logic [15:0] wd,
                      input int acc_off, input int ack_off, input bit err,
                      input logic [15:0] rd);
      ack_t k;
      bit got = 1'b0;
      issue(we, addr, wd, acc_off);
      k.cyc = cyc + ack_off; k.err = err; k.rd = rd;
      ack_q.push_back(k);
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (dbg.DBG_ACK) begin
            got = 1'b1;
            dbg.DBG_REQ = 1'b0;
         end
      end
      check("ack_timeout", 32'(got), 32'd1);
      dbg.DBG_REQ = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ack"}, 32'(dbg.DBG_ACK), 32'd0);
      check({tag, "_err"}, 32'(dbg.DBG_ERR), 32'd0);
      check({tag, "_rdata"}, dbg.DBG_RDATA, 32'd0);
      check({tag, "_port"}, {REGA_EN, REGA_WEN, REGA_BYTE_EN, ADDRA, DIN_SEL},
            {CORE_REGA_EN, CORE_REGA_WEN, CORE_BYTE_EN, CORE_ADDRA, 1'b0});
   endtask

   initial begin
      RESET = 1'b1;
      dbg.DBG_REQ = 1'b0; dbg.DBG_WE = 1'b0; dbg.DBG_ADDR = '0; dbg.DBG_WDATA = '0;
      ph = 3; core_on = 1'b1; core_force = 1'b0; halt_on = 1'b0;
      last_rd = 16'h0000;
      drive_phase();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset_checks("reset");
      RESET = 1'b0;
      tick();

      // Write in COMMIT: slot is the following FETCH, ACCESS in DECODE
      goto_phase(3);
      req(1'b1, 4'd3, 16'hA5C3, 2, 3, 1'b0, last_rd);

      // Read requested in FETCH must skip DECODE and wait for the next FETCH
      goto_phase(0);
      last_rd = 16'hA5C3;
      req(1'b0, 4'd3, 16'h0000, 5, 7, 1'b0, last_rd);

      // Back-to-back writes
      goto_phase(2);
      req(1'b1, 4'd5, 16'h0F0F, 3, 4, 1'b0, last_rd);
      tick();
      req(1'b1, 4'd9, 16'hBEEF, 2, 3, 1'b0, last_rd);

      // HALT: every cycle is a slot
      halt_on = 1'b1;
      tick();
      req(1'b1, 4'd7, 16'h7E57, 2, 3, 1'b0, last_rd);
      tick();
      last_rd = 16'h0F0F;
      req(1'b0, 4'd5, 16'h0000, 2, 4, 1'b0, last_rd);
      tick();
      last_rd = 16'hBEEF;
      req(1'b0, 4'd9, 16'h0000, 2, 4, 1'b0, last_rd);
      tick();
      last_rd = 16'h7E57;
      req(1'b0, 4'd7, 16'h0000, 2, 4, 1'b0, last_rd);

      // Core holds port A forever: timeout with ERR, read data unchanged
      halt_on = 1'b0;
      core_force = 1'b1;
      tick();
      req(1'b0, 4'd3, 16'h0000, 0, MW + 2, 1'b1, last_rd);

      // Reset while waiting for a slot
      tick();
      issue(1'b0, 4'd3, 16'h0000, 0);
      repeat (3) tick();
      #2 RESET = 1'b1;
      #1 reset_checks("rst_wait");
      dbg.DBG_REQ = 1'b0;
      acc_q.delete(); ack_q.delete();
      tick();
      RESET = 1'b0;
      #1 reset_checks("post_rst_wait");
      repeat (3) tick();

      // Reset while capturing read data
      core_force = 1'b0;
      halt_on = 1'b1;
      tick();
      req(1'b0, 4'd3, 16'h0000, 2, 4, 1'b0, 16'hA5C3);
      tick();
      issue(1'b0, 4'd7, 16'h0000, 2);
      repeat (3) tick();
      #2 RESET = 1'b1;
      #1 reset_checks("rst_capture");
      dbg.DBG_REQ = 1'b0;
      acc_q.delete(); ack_q.delete();
      tick();
      RESET = 1'b0;
      #1 reset_checks("post_rst_capture");
      repeat (3) tick();

      // Recovery after reset
      req(1'b0, 4'd7, 16'h0000, 2, 4, 1'b0, 16'h7E57);
      repeat (3) tick();
      check("scoreboard_drained", 32'(acc_q.size() + ack_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
